// File: rtl/roam_controller.sv
// Overworld roam controller: tile-stepped trainer movement, enemy
// interaction, defeated tracking and room exit for NUM_ENEMY slots.
module roam_controller #(
  parameter int NUM_ENEMY  = 4,
  parameter int MAP_X      = 224,
  parameter int MAP_Y      = 100,
  parameter int MAP_W      = 192,
  parameter int MAP_H      = 255,
  parameter int SPR_W      = 14,
  parameter int SPR_H      = 16,
  parameter int TILE       = 16,
  parameter int STEP       = 1,
  parameter int REACH      = 3,
  parameter int TOP_MARGIN = 25,
  parameter int START_X    = 313,
  parameter int START_Y    = 336
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     frame_clk,
  input  logic                     is_roam,
  input  logic                     is_start,
  input  logic [7:0]               keycode,
  input  logic                     battle_done,
  input  logic [10*NUM_ENEMY-1:0]  enemy_x,
  input  logic [10*NUM_ENEMY-1:0]  enemy_y,
  input  logic [NUM_ENEMY-1:0]     enemy_active,
  output logic [9:0]               trainer_x,
  output logic [9:0]               trainer_y,
  output logic [1:0]               trainer_dir,
  output logic                     walking,
  output logic                     start_battle,
  output logic [2:0]               battle_idx,
  output logic [NUM_ENEMY-1:0]     defeated,
  output logic                     new_room
);

  typedef enum logic [1:0] {IDLE, WALK, BATTLE} state_t;

  localparam int RW = $clog2(TILE + 1);
  localparam logic [10:0] LIM_T = 11'(MAP_Y + TOP_MARGIN);
  localparam logic [10:0] LIM_B = 11'(MAP_Y + MAP_H);
  localparam logic [10:0] LIM_L = 11'(MAP_X);
  localparam logic [10:0] LIM_R = 11'(MAP_X + MAP_W);
  localparam logic [10:0] TL    = 11'(TILE);
  localparam logic [10:0] SW    = 11'(SPR_W);
  localparam logic [10:0] SH    = 11'(SPR_H);
  localparam logic [10:0] RCH   = 11'(REACH);
  localparam logic [9:0]  ST    = 10'(STEP);
  localparam logic [9:0]  SX    = 10'(START_X);
  localparam logic [9:0]  SY    = 10'(START_Y);
  localparam logic [7:0]  K_W   = 8'h1A;
  localparam logic [7:0]  K_A   = 8'h04;
  localparam logic [7:0]  K_S   = 8'h16;
  localparam logic [7:0]  K_D   = 8'h07;
  localparam logic [7:0]  K_EN  = 8'h28;

  state_t               state_q;
  logic [9:0]           x_q, y_q;
  logic [1:0]           dir_q;
  logic [RW-1:0]        rem_q;
  logic [2:0]           idx_q;
  logic [NUM_ENEMY-1:0] def_q;
  logic                 start_q, room_q;
  logic [1:0]           frm_q;

  logic                 frame_tick;
  logic                 key_ok;
  logic [1:0]           key_dir;
  logic [10:0]          tx, ty, nx, ny;
  logic [10:0]          ex, ey, dx, dy;
  logic                 bound_blk, hit, blocked;
  logic                 f;
  logic [NUM_ENEMY-1:0] face;
  logic [2:0]           face_idx;
  logic                 exit_ok;

  always_ff @(posedge Clk) begin
    if (Reset) frm_q <= 2'b00;
    else       frm_q <= {frm_q[0], frame_clk};
  end

  assign frame_tick = frm_q[0] & ~frm_q[1];

  assign tx = {1'b0, x_q};
  assign ty = {1'b0, y_q};

  always_comb begin
    key_ok  = 1'b1;
    key_dir = 2'd0;
    case (keycode)
      K_W:     key_dir = 2'd0;
      K_S:     key_dir = 2'd1;
      K_A:     key_dir = 2'd2;
      K_D:     key_dir = 2'd3;
      default: key_ok  = 1'b0;
    endcase
  end

  // Bounds are phrased on the current position so nothing can wrap.
  always_comb begin
    nx        = tx;
    ny        = ty;
    bound_blk = 1'b0;
    case (dir_q)
      2'd0: begin
        ny        = ty - TL;
        bound_blk = ty < LIM_T + TL;
      end
      2'd1: begin
        ny        = ty + TL;
        bound_blk = ny + SH > LIM_B;
      end
      2'd2: begin
        nx        = tx - TL;
        bound_blk = tx < LIM_L + TL;
      end
      default: begin
        nx        = tx + TL;
        bound_blk = nx + SW > LIM_R;
      end
    endcase
  end

  always_comb begin
    hit      = 1'b0;
    face     = '0;
    face_idx = 3'd0;
    ex       = '0;
    ey       = '0;
    dx       = '0;
    dy       = '0;
    f        = 1'b0;
    for (int k = 0; k < NUM_ENEMY; k++) begin
      ex = {1'b0, enemy_x[10*k +: 10]};
      ey = {1'b0, enemy_y[10*k +: 10]};
      dx = (tx >= ex) ? tx - ex : ex - tx;
      dy = (ty >= ey) ? ty - ey : ey - ty;
      if (enemy_active[k] && nx < ex + SW && ex < nx + SW &&
          ny < ey + SH && ey < ny + SH)
        hit = 1'b1;
      case (dir_q)
        2'd0: f = dx <= RCH && ey + SH <= ty && ty <= ey + SH + RCH;
        2'd1: f = dx <= RCH && ey <= ty + SH + RCH && ty + SH <= ey;
        2'd2: f = dy <= RCH && ex + SW <= tx && tx <= ex + SW + RCH;
        default:
              f = dy <= RCH && ex <= tx + SW + RCH && tx + SW <= ex;
      endcase
      face[k] = enemy_active[k] & ~def_q[k] & f;
    end
    for (int k = NUM_ENEMY - 1; k >= 0; k--)
      if (face[k]) face_idx = 3'(k);
  end

  assign blocked = bound_blk | hit;
  assign exit_ok = (|enemy_active) &&
                   ((enemy_active & ~def_q) == '0) &&
                   (ty <= LIM_T);

  always_ff @(posedge Clk) begin
    if (Reset || is_start) begin
      state_q <= IDLE;
      x_q     <= SX;
      y_q     <= SY;
      dir_q   <= 2'd0;
      rem_q   <= '0;
      idx_q   <= 3'd0;
      def_q   <= '0;
      start_q <= 1'b0;
      room_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      room_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (is_roam && keycode == K_EN && |face) begin
            start_q <= 1'b1;
            idx_q   <= face_idx;
            state_q <= BATTLE;
          end else if (frame_tick) begin
            if (exit_ok) begin
              room_q <= 1'b1;
              x_q    <= SX;
              y_q    <= SY;
              dir_q  <= 2'd0;
              def_q  <= '0;
            end else if (is_roam && key_ok) begin
              if (key_dir != dir_q) begin
                dir_q <= key_dir;
              end else if (!blocked) begin
                rem_q   <= RW'(TILE);
                state_q <= WALK;
              end
            end
          end
        end
        WALK: begin
          if (frame_tick && is_roam) begin
            case (dir_q)
              2'd0:    y_q <= y_q - ST;
              2'd1:    y_q <= y_q + ST;
              2'd2:    x_q <= x_q - ST;
              default: x_q <= x_q + ST;
            endcase
            rem_q <= rem_q - RW'(STEP);
            if (rem_q == RW'(STEP)) state_q <= IDLE;
          end
        end
        BATTLE: begin
          if (battle_done) begin
            for (int k = 0; k < NUM_ENEMY; k++)
              if (idx_q == 3'(k)) def_q[k] <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign trainer_x    = x_q;
  assign trainer_y    = y_q;
  assign trainer_dir  = dir_q;
  assign walking      = (state_q == WALK);
  assign start_battle = start_q;
  assign battle_idx   = idx_q;
  assign defeated     = def_q;
  assign new_room     = room_q;

endmodule

// File: tb/tb_roam_controller.sv
// Scoreboard bench for roam_controller: two instances, the second
// spawning at y=141 so a full-clear room exit is reachable.
module tb_roam_controller;

  localparam int NE = 4;

  logic          Clk = 1'b0;
  logic          Reset, frame_clk, is_roam, is_start, battle_done;
  logic [7:0]    keycode;
  logic [10*NE-1:0] enemy_x, enemy_y;
  logic [NE-1:0] enemy_active;

  logic [9:0]    x1, y1, x2, y2;
  logic [1:0]    d1, d2;
  logic          w1, w2, sb1, sb2, nr1, nr2;
  logic [2:0]    i1, i2;
  logic [NE-1:0] df1, df2;

  always #5 Clk = ~Clk;

  roam_controller u_dut1 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .is_roam(is_roam), .is_start(is_start), .keycode(keycode),
    .battle_done(battle_done), .enemy_x(enemy_x),
    .enemy_y(enemy_y), .enemy_active(enemy_active),
    .trainer_x(x1), .trainer_y(y1), .trainer_dir(d1),
    .walking(w1), .start_battle(sb1), .battle_idx(i1),
    .defeated(df1), .new_room(nr1)
  );

  roam_controller #(.START_Y(141)) u_dut2 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .is_roam(is_roam), .is_start(is_start), .keycode(keycode),
    .battle_done(battle_done), .enemy_x(enemy_x),
    .enemy_y(enemy_y), .enemy_active(enemy_active),
    .trainer_x(x2), .trainer_y(y2), .trainer_dir(d2),
    .walking(w2), .start_battle(sb2), .battle_idx(i2),
    .defeated(df2), .new_room(nr2)
  );

  typedef struct {
    bit         d;
    string      n;
    logic [9:0] x, y;
    logic [1:0] dir;
    logic       w;
    logic [3:0] def;
  } snap_t;

  typedef struct {
    bit         d;
    bit         room;
    logic [2:0] idx;
  } pulse_t;

  snap_t  snap_q[$];
  pulse_t pulse_q[$];
  int     checks = 0;
  int     errors = 0;
  bit     done = 1'b0;

  snap_t  cs;
  pulse_t cp;
  logic [9:0] ax, ay;
  logic [1:0] ad;
  logic       aw;
  logic [3:0] adf;

  task automatic pulse_chk(input bit d, input logic sb,
                           input logic nr, input logic [2:0] idx);
    if (sb || nr) begin
      checks++;
      if (pulse_q.size() == 0) begin
        errors++;
        $display("FAIL pulse dut%0d: got sb=%b nr=%b, want none",
                 d, sb, nr);
      end else begin
        cp = pulse_q.pop_front();
        if (cp.d != d || cp.room != nr || cp.room == sb ||
            (!cp.room && idx !== cp.idx)) begin
          errors++;
          $display("FAIL pulse dut%0d: got sb=%b nr=%b idx=%0d, want dut%0d room=%b idx=%0d",
                   d, sb, nr, idx, cp.d, cp.room, cp.idx);
        end
      end
    end
  endtask

  always @(negedge Clk) begin
    pulse_chk(1'b0, sb1, nr1, i1);
    pulse_chk(1'b1, sb2, nr2, i2);
    while (snap_q.size() > 0) begin
      cs  = snap_q.pop_front();
      ax  = cs.d ? x2 : x1;
      ay  = cs.d ? y2 : y1;
      ad  = cs.d ? d2 : d1;
      aw  = cs.d ? w2 : w1;
      adf = cs.d ? df2 : df1;
      checks++;
      if ({ax, ay, ad, aw, adf} !== {cs.x, cs.y, cs.dir, cs.w, cs.def}) begin
        errors++;
        $display("FAIL %s: got x=%0d y=%0d dir=%0d walk=%b def=%b, want x=%0d y=%0d dir=%0d walk=%b def=%b",
                 cs.n, ax, ay, ad, aw, adf,
                 cs.x, cs.y, cs.dir, cs.w, cs.def);
      end
    end
    if (done) begin
      while (pulse_q.size() > 0) begin
        cp = pulse_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing pulse: got none, want dut%0d room=%b idx=%0d",
                 cp.d, cp.room, cp.idx);
      end
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic frame();
    frame_clk = 1'b1;
    cyc(2);
    frame_clk = 1'b0;
    cyc(2);
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic chk(input bit d, input string n, input int x,
                     input int y, input int dir, input bit w,
                     input logic [3:0] def);
    snap_t s;
    s.d = d; s.n = n; s.x = 10'(x); s.y = 10'(y);
    s.dir = 2'(dir); s.w = w; s.def = def;
    #1 snap_q.push_back(s);
    @(negedge Clk);
  endtask

  task automatic exp_pulse(input bit d, input bit room, input int idx);
    pulse_t p;
    p.d = d; p.room = room; p.idx = 3'(idx);
    pulse_q.push_back(p);
  endtask

  task automatic win();
    battle_done = 1'b1;
    cyc(1);
    battle_done = 1'b0;
  endtask

  localparam logic [7:0] K_W  = 8'h1A;
  localparam logic [7:0] K_A  = 8'h04;
  localparam logic [7:0] K_EN = 8'h28;

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; is_roam = 1'b0;
    is_start = 1'b0; battle_done = 1'b0; keycode = 8'h00;
    enemy_x = '0; enemy_y = '0; enemy_active = '0;
    cyc(3);
    Reset = 1'b0;
    chk(0, "reset", 313, 336, 0, 0, 4'b0000);
    chk(1, "reset2", 313, 141, 0, 0, 4'b0000);
    win();
    chk(0, "bdone_idle", 313, 336, 0, 0, 4'b0000);

    is_roam = 1'b1;
    keycode = K_W;
    frame();
    chk(0, "walk_start", 313, 336, 0, 1, 4'b0000);
    frames(6);
    chk(0, "walk_330", 313, 330, 0, 1, 4'b0000);
    is_start = 1'b1;
    cyc(1);
    is_start = 1'b0;
    chk(0, "is_start", 313, 336, 0, 0, 4'b0000);

    frame();
    chk(0, "step_start", 313, 336, 0, 1, 4'b0000);
    frames(8);
    chk(0, "step_mid", 313, 328, 0, 1, 4'b0000);
    frames(8);
    chk(0, "step_done", 313, 320, 0, 0, 4'b0000);

    frame();
    is_roam = 1'b0;
    frames(3);
    chk(0, "roam_freeze", 313, 320, 0, 1, 4'b0000);
    is_roam = 1'b1;
    frames(16);
    chk(0, "roam_resume", 313, 304, 0, 0, 4'b0000);

    keycode = K_A;
    frame();
    chk(0, "turn_left", 313, 304, 2, 0, 4'b0000);
    keycode = K_W;
    frame();
    chk(0, "turn_up", 313, 304, 0, 0, 4'b0000);

    enemy_x = {10'd0, 10'd0, 10'd0, 10'd313};
    enemy_y = {10'd0, 10'd0, 10'd0, 10'd224};
    enemy_active = 4'b0001;
    frames(68);
    chk(0, "reach_240", 313, 240, 0, 0, 4'b0000);
    frame();
    chk(0, "enemy_block", 313, 240, 0, 0, 4'b0000);

    exp_pulse(0, 0, 0);
    keycode = K_EN;
    cyc(3);
    keycode = K_W;
    frames(2);
    chk(0, "battle_freeze", 313, 240, 0, 0, 4'b0000);
    win();
    chk(0, "won", 313, 240, 0, 0, 4'b0001);
    keycode = K_EN;
    cyc(4);
    keycode = K_W;
    frame();
    chk(0, "dead_blocks", 313, 240, 0, 0, 4'b0001);

    Reset = 1'b1;
    cyc(1);
    Reset = 1'b0;
    enemy_x = {10'd0, 10'd0, 10'd299, 10'd313};
    enemy_y = {10'd0, 10'd0, 10'd125, 10'd109};
    enemy_active = 4'b0011;
    frames(17);
    chk(1, "walk2_125", 313, 125, 0, 0, 4'b0000);
    chk(0, "walk1_320", 313, 320, 0, 0, 4'b0000);
    exp_pulse(1, 0, 0);
    keycode = K_EN;
    cyc(2);
    keycode = 8'h00;
    win();
    chk(1, "won0", 313, 125, 0, 0, 4'b0001);
    keycode = K_A;
    frame();
    chk(1, "turn2", 313, 125, 2, 0, 4'b0001);
    exp_pulse(1, 0, 1);
    keycode = K_EN;
    cyc(2);
    keycode = 8'h00;
    win();
    chk(1, "won1", 313, 125, 2, 0, 4'b0011);
    exp_pulse(1, 1, 0);
    keycode = K_W;
    frame();
    chk(1, "new_room", 313, 141, 0, 0, 4'b0000);
    chk(0, "no_exit1", 313, 320, 0, 0, 4'b0000);
    keycode = 8'h00;
    cyc(2);
    done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end, want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/roam_controller.md
Name: roam_controller

Overview:
- Overworld movement and encounter controller that generalises the single-enemy roaming logic to NUM_ENEMY parametrised enemies.
- Movement is tile-stepped: one key press commits a full TILE-pixel step, animated at STEP pixels per frame.
- Tracks which enemies have been defeated, issues battle start requests, and raises a room exit once every active enemy is beaten.
- Sits between the keyboard/keycode path and the battle engine; its position and direction outputs feed the roam sprite renderer.

Parameters:
- NUM_ENEMY, 4, number of enemy slots (1..8)
- MAP_X, 224, map left edge (pixels)
- MAP_Y, 100, map top edge
- MAP_W, 192, map width
- MAP_H, 255, map height
- SPR_W, 14, trainer/enemy sprite width
- SPR_H, 16, trainer/enemy sprite height
- TILE, 16, pixels per committed step; must be a multiple of STEP
- STEP, 1, pixels moved per frame tick while walking
- REACH, 3, interaction alignment/distance tolerance
- TOP_MARGIN, 25, unwalkable band below MAP_Y
- START_X, 313, spawn x
- START_Y, 336, spawn y

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous active-high reset
- frame_clk  in  1  vsync-rate frame clock (asynchronous level, sampled on Clk)
- is_roam  in  1  game is in roam mode
- is_start  in  1  title screen active; acts as a soft reset
- keycode  in  8  current key: W=1A, A=04, S=16, D=07, ENTER=28
- battle_done  in  1  one-cycle pulse from the battle engine meaning the player won
- enemy_x  in  10*NUM_ENEMY  packed enemy x positions, slot k at bits [10k+9:10k]
- enemy_y  in  10*NUM_ENEMY  packed enemy y positions
- enemy_active  in  NUM_ENEMY  slot present in this room
- trainer_x  out  10  trainer top-left x
- trainer_y  out  10  trainer top-left y
- trainer_dir  out  2  0=up, 1=down, 2=left, 3=right
- walking  out  1  a step is in progress
- start_battle  out  1  one-cycle pulse
- battle_idx  out  3  enemy index of the current or last battle
- defeated  out  NUM_ENEMY  per-slot defeated flags
- new_room  out  1  one-cycle pulse

Behaviour:
- Reset or is_start: trainer_x=START_X, trainer_y=START_Y, dir=0, state=IDLE, remaining=0, defeated=0, battle_idx=0. All pulse outputs read 0.
- frame_tick: frame_clk is registered. frame_tick is high for exactly one Clk cycle, one cycle after a 0->1 transition is sampled.
- States: IDLE, WALK, BATTLE. walking=1 only in WALK.
- IDLE, on frame_tick with is_roam=1 and a direction key pressed:
  - If the key's direction differs from dir: update dir only; position is unchanged.
  - Otherwise compute the target position = position ± TILE on the key's axis.
  - The move is blocked if W target_y < MAP_Y+TOP_MARGIN.
  - Blocked if S target_y+SPR_H > MAP_Y+MAP_H.
  - Blocked if A target_x < MAP_X.
  - Blocked if D target_x+SPR_W > MAP_X+MAP_W.
  - Blocked if the target box overlaps any active enemy box; defeated enemies still block.
  - All bound arithmetic is 11-bit unsigned so a subtraction cannot wrap.
  - Not blocked: go to WALK with remaining=TILE. Blocked: stay in IDLE.
- WALK, on each frame_tick with is_roam=1:
  - Position moves STEP pixels in dir; remaining -= STEP.
  - When remaining reaches 0, go to IDLE on that same cycle.
  - Keys are ignored in WALK.
  - With is_roam=0, WALK freezes in place.
- Interaction is evaluated every Clk in IDLE with is_roam=1 and keycode=ENTER. An enemy k is facing when it is active, not defeated, and:
  - dir=0: |tx-ex|<=REACH and ey+SPR_H <= ty <= ey+SPR_H+REACH.
  - dir=1: |tx-ex|<=REACH and ey-REACH <= ty+SPR_H <= ey.
  - dir=2: |ty-ey|<=REACH and ex+SPR_W <= tx <= ex+SPR_W+REACH.
  - dir=3: |ty-ey|<=REACH and ex-REACH <= tx+SPR_W <= ex.
  - If any slot is facing: pulse start_battle for one cycle, set battle_idx to the lowest facing index, go to BATTLE.
  - ENTER held after the battle does not retrigger on that enemy, because it is now defeated.
- BATTLE: movement and ENTER are ignored. On battle_done: defeated[battle_idx]<=1, go to IDLE. battle_done outside BATTLE is ignored.
- Exit, in IDLE on frame_tick, requires enemy_active≠0, every active slot defeated, and trainer_y <= MAP_Y+TOP_MARGIN. Then:
  - pulse new_room;
  - position returns to START, dir=0, defeated cleared.
  - Exit takes priority over a direction key on the same tick.
- Reset or is_start mid-WALK or mid-BATTLE aborts immediately to the reset state.

Test Plan:
- Reset, dir=0, hold W for 16 frames -> walking=1 for 16 ticks; trainer_y goes 336->320, 1 px per tick; then IDLE.
- From dir=0, press A for 1 frame -> trainer_dir=2, trainer_x stays 313, walking stays 0.
- Enemy 0 at (313,224), active; hold W -> trainer stops at y=240. Next W tick is blocked: y=240, walking=0.
- At y=240, dir=0, ENTER -> start_battle high exactly 1 cycle, battle_idx=0, state BATTLE. W presses then have no effect until battle_done, after which defeated=0001.
- Enemies 0 and 1 active, both defeated, trainer at y=125 -> new_room pulse on next frame_tick; position (313,336); defeated=0.
- Assert is_start during WALK at y=330 -> next cycle position (313,336), walking=0, dir=0.
